// File: rtl/ble_tx_modulator.sv
// BLE 1 Mbps transmitter: preamble/AA/PDU/CRC24 framing with MSK-style CPFSK onto 4-bit I/Q.
// Define BLE_TX_WHITEN_EN to include the channel whitening LFSR on PDU and CRC bits.
module ble_tx_modulator #(
  parameter int unsigned SPS      = 8,
  parameter logic [23:0] CRC_INIT = 24'h555555
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] aa,
  input  logic [5:0]  chan_idx,
  input  logic [7:0]  pdu_len,
  input  logic [7:0]  data,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic        tx_en,
  output logic        tx_bit,
  output logic        sym_strobe,
  output logic [3:0]  I_out,
  output logic [3:0]  Q_out
);

  localparam int unsigned SW       = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int unsigned CW       = 9;
  localparam logic [23:0] CRC_POLY = 24'h00065B;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_AA, S_PDU, S_CRC, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [39:0]   sr_q, sr_d;
  logic [23:0]   crc_q, crc_d;
  logic [5:0]    len_q, len_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [5:0]    fetched_q, fetched_d;
  logic          underrun_q, underrun_d;
  logic [4:0]    ph_q, ph_d;

  logic          data_ready_q, data_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tx_en_q, tx_en_d;
  logic          tx_bit_q, tx_bit_d;
  logic          sym_strobe_q, sym_strobe_d;
  logic [3:0]    i_q, i_d;
  logic [3:0]    q_q, q_d;

  logic          take, byte_avail, sym_end, pdu_last, crc_fb;
  logic [7:0]    byte_next;
  logic          wh_seed, wh_step, whiten_bit;
  logic          run_d, raw_d;

  // round(7*cos(2*pi*p/32)) by folding the phase into the first quadrant
  function automatic logic [3:0] cos7(input logic [4:0] p);
    logic [4:0] r;
    logic [4:0] f;
    logic       neg;
    logic [3:0] m;
    r   = p[4] ? (5'd0 - p) : p;
    neg = (r > 5'd8);
    f   = neg ? (5'd16 - r) : r;
    case (f)
      5'd0, 5'd1: m = 4'd7;
      5'd2, 5'd3: m = 4'd6;
      5'd4:       m = 4'd5;
      5'd5:       m = 4'd4;
      5'd6:       m = 4'd3;
      5'd7:       m = 4'd1;
      default:    m = 4'd0;
    endcase
    return neg ? (4'd0 - m) : m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      samp_q       <= '0;
      cnt_q        <= '0;
      sr_q         <= '0;
      crc_q        <= '0;
      len_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      fetched_q    <= '0;
      underrun_q   <= 1'b0;
      ph_q         <= '0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tx_en_q      <= 1'b0;
      tx_bit_q     <= 1'b0;
      sym_strobe_q <= 1'b0;
      i_q          <= '0;
      q_q          <= '0;
    end else begin
      state_q      <= state_d;
      samp_q       <= samp_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      crc_q        <= crc_d;
      len_q        <= len_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      fetched_q    <= fetched_d;
      underrun_q   <= underrun_d;
      ph_q         <= ph_d;
      data_ready_q <= data_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tx_en_q      <= tx_en_d;
      tx_bit_q     <= tx_bit_d;
      sym_strobe_q <= sym_strobe_d;
      i_q          <= i_d;
      q_q          <= q_d;
    end
  end

  // Sequencing, byte handshake, CRC; fields advance only at symbol ends
  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    crc_d       = crc_q;
    len_d       = len_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    fetched_d   = fetched_q;
    underrun_d  = underrun_q;
    wh_seed     = 1'b0;
    wh_step     = 1'b0;
    take        = data_valid && data_ready_q;
    byte_avail  = hold_full_q || take;
    byte_next   = hold_full_q ? hold_q : data;
    sym_end     = (samp_q == SW'(SPS - 1));
    pdu_last    = (cnt_q == {len_q - 6'd1, 3'b111});
    crc_fb      = crc_q[23] ^ sr_q[0];

    if (take) begin
      hold_d      = data;
      hold_full_d = 1'b1;
      fetched_d   = fetched_q + 6'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_PRE;
          samp_d      = '0;
          cnt_d       = '0;
          sr_d        = {aa, aa[0] ? 8'h55 : 8'hAA};
          crc_d       = CRC_INIT;
          len_d       = (pdu_len < 8'd2) ? 6'd2 : (pdu_len > 8'd39) ? 6'd39 : pdu_len[5:0];
          hold_full_d = 1'b0;
          fetched_d   = '0;
          underrun_d  = 1'b0;
          wh_seed     = 1'b1;
        end
      end
      S_PRE, S_AA, S_PDU, S_CRC: begin
        samp_d = sym_end ? '0 : samp_q + SW'(1);
        if (sym_end) begin
          cnt_d = cnt_q + CW'(1);
          sr_d  = sr_q >> 1;
          case (state_q)
            S_PRE: begin
              if (cnt_q == CW'(7)) begin
                state_d = S_AA;
                cnt_d   = '0;
              end
            end
            S_AA: begin
              if (cnt_q == CW'(31)) begin
                cnt_d = '0;
                if (byte_avail) begin
                  state_d     = S_PDU;
                  sr_d        = {32'h0, byte_next};
                  hold_full_d = 1'b0;
                end else begin
                  state_d    = S_DONE;
                  underrun_d = 1'b1;
                end
              end
            end
            S_PDU: begin
              crc_d   = {crc_q[22:0], 1'b0} ^ (crc_fb ? CRC_POLY : 24'h0);
              wh_step = 1'b1;
              if (pdu_last) begin
                state_d = S_CRC;
                cnt_d   = '0;
              end else if (cnt_q[2:0] == 3'd7) begin
                if (byte_avail) begin
                  sr_d        = {32'h0, byte_next};
                  hold_full_d = 1'b0;
                end else begin
                  state_d    = S_DONE;
                  underrun_d = 1'b1;
                end
              end
            end
            S_CRC: begin
              crc_d   = {crc_q[22:0], 1'b0};
              wh_step = 1'b1;
              if (cnt_q == CW'(23)) state_d = S_DONE;
            end
            default: ;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BLE_TX_WHITEN_EN
  logic [6:0] wh_q, wh_d;

  // wh[i] is LFSR position i; channel MSB sits at position 1
  always_comb begin
    wh_d = wh_q;
    if (wh_seed) begin
      wh_d = {chan_idx[0], chan_idx[1], chan_idx[2], chan_idx[3], chan_idx[4], chan_idx[5], 1'b1};
    end else if (wh_step) begin
      wh_d = {wh_q[5], wh_q[4], wh_q[3] ^ wh_q[6], wh_q[2], wh_q[1], wh_q[0], wh_q[6]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wh_q <= '0;
    else     wh_q <= wh_d;
  end

  assign whiten_bit = wh_d[6];
`else
  logic unused_whiten;
  assign whiten_bit    = 1'b0;
  assign unused_whiten = ^{chan_idx, wh_seed, wh_step};
`endif

  // Registered outputs describe the cycle being entered, so phase includes this cycle's step
  always_comb begin
    run_d        = (state_d inside {S_PRE, S_AA, S_PDU, S_CRC});
    raw_d        = (state_d == S_CRC) ? crc_d[23] : sr_d[0];
    tx_en_d      = run_d;
    busy_d       = run_d;
    done_d       = (state_d == S_DONE);
    sym_strobe_d = run_d && (samp_d == '0);
    tx_bit_d     = run_d && (raw_d ^ ((state_d inside {S_PDU, S_CRC}) && whiten_bit));
    ph_d         = run_d ? (tx_bit_d ? ph_q + 5'd1 : ph_q - 5'd1) : 5'd0;
    i_d          = run_d ? cos7(ph_d) : 4'd0;
    q_d          = run_d ? cos7(ph_d - 5'd8) : 4'd0;
    data_ready_d = (state_d inside {S_AA, S_PDU}) && !hold_full_d && (fetched_d < len_d);
  end

  assign data_ready = data_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underrun   = underrun_q;
  assign tx_en      = tx_en_q;
  assign tx_bit     = tx_bit_q;
  assign sym_strobe = sym_strobe_q;
  assign I_out      = i_q;
  assign Q_out      = q_q;

endmodule

// File: tb/tb_ble_tx_modulator.sv
// Directed bench for ble_tx_modulator: framing, CRC/whitening model, I/Q samples, underrun, reset.
module tb_ble_tx_modulator;

  localparam int SPS = 8;

`ifdef BLE_TX_WHITEN_EN
  localparam bit WH = 1'b1;
`else
  localparam bit WH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] aa;
  logic [5:0]  chan_idx;
  logic [7:0]  pdu_len;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_ready, busy, done, underrun, tx_en, tx_bit, sym_strobe;
  logic [3:0]  I_out, Q_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] pdu [0:63];
  bit         eb  [0:511];
  int         nb;

  int cos_t [32] = '{7, 7, 6, 6, 5, 4, 3, 1, 0, -1, -3, -4, -5, -6, -6, -7,
                     -7, -7, -6, -6, -5, -4, -3, -1, 0, 1, 3, 4, 5, 6, 6, 7};
  int sin_t [32] = '{0, 1, 3, 4, 5, 6, 6, 7, 7, 7, 6, 6, 5, 4, 3, 1,
                     0, -1, -3, -4, -5, -6, -6, -7, -7, -7, -6, -6, -5, -4, -3, -1};

  ble_tx_modulator #(.SPS(SPS), .CRC_INIT(24'h555555)) dut (
    .clk(clk), .rst(rst), .start(start), .aa(aa), .chan_idx(chan_idx),
    .pdu_len(pdu_len), .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done), .underrun(underrun), .tx_en(tx_en), .tx_bit(tx_bit),
    .sym_strobe(sym_strobe), .I_out(I_out), .Q_out(Q_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expected on-air bit stream: preamble, AA, PDU and CRC (whitened when enabled)
  task automatic build_model(input logic [31:0] a, input logic [5:0] ch, input int len);
    logic [7:0]  pre;
    logic [23:0] crc;
    bit          pos [7];
    bit          b, fb, t;
    nb  = 0;
    pre = a[0] ? 8'h55 : 8'hAA;
    for (int i = 0; i < 8; i++) begin eb[nb] = pre[i]; nb++; end
    for (int i = 0; i < 32; i++) begin eb[nb] = a[i]; nb++; end
    crc    = 24'h555555;
    pos[0] = 1'b1;
    for (int j = 1; j < 7; j++) pos[j] = ch[6-j];
    for (int n = 0; n < len * 8 + 24; n++) begin
      if (n < len * 8) begin
        b   = pdu[n / 8][n % 8];
        fb  = b ^ crc[23];
        crc = {crc[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h0);
      end else begin
        b = crc[23 - (n - len * 8)];
      end
      eb[nb] = b ^ (WH & pos[6]);
      nb++;
      t = pos[6];
      for (int j = 6; j > 0; j--) pos[j] = pos[j-1];
      pos[4] = pos[4] ^ t;
      pos[0] = t;
    end
  endtask

  task automatic run_packet(input string name, input logic [31:0] a, input logic [5:0] ch,
                            input logic [7:0] len_in, input int withhold, input int poke,
                            input bit dir);
    int len, air, offer, taken, ph, sym;
    int bit_err, stb_err, en_err, iq_err;
    bit expb, tk;
    len = (len_in < 8'd2) ? 2 : (len_in > 8'd39) ? 39 : int'(len_in);
    build_model(a, ch, len);
    air     = (withhold > 0) ? (40 + 8 * withhold) * SPS : nb * SPS;
    offer   = (withhold > 0) ? withhold : len;
    taken   = 0; ph = 0;
    bit_err = 0; stb_err = 0; en_err = 0; iq_err = 0;
    @(posedge clk); #1;
    aa = a; chan_idx = ch; pdu_len = len_in; start = 1'b1;
    data_valid = 1'b1; data = pdu[0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= air + 3; k++) begin
      @(negedge clk);
      tk = data_ready && data_valid;
      if (k <= air) begin
        sym  = (k - 1) / SPS;
        expb = eb[sym];
        ph   = (ph + (expb ? 1 : 31)) % 32;
        if (tx_bit !== expb) bit_err++;
        if (sym_strobe !== (((k - 1) % SPS) == 0)) stb_err++;
        if (tx_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || underrun !== 1'b0) en_err++;
        if (I_out !== 4'(cos_t[ph]) || Q_out !== 4'(sin_t[ph])) iq_err++;
        if (dir) begin
          if (k == 1)  check({name, "_pre_bit0"}, 32'(tx_bit), 0);
          if (k == 9)  check({name, "_pre_bit1"}, 32'(tx_bit), 1);
          if (k == 65) check({name, "_aa_bit0"}, 32'(tx_bit), 0);
          if (k == 73) check({name, "_aa_bit1"}, 32'(tx_bit), 1);
          if (k == 89) check({name, "_aa_bit3"}, 32'(tx_bit), 0);
          if (k == 8) begin
            check({name, "_ph24_I"}, 32'(I_out), 0);
            check({name, "_ph24_Q"}, 32'(Q_out), 32'(4'b1001));
          end
          if (k == 16) begin
            check({name, "_ph0_I"}, 32'(I_out), 7);
            check({name, "_ph0_Q"}, 32'(Q_out), 0);
          end
        end
      end else if (k == air + 1) begin
        check({name, "_done"}, 32'(done), 1);
        check({name, "_end_tx_en"}, 32'(tx_en), 0);
        check({name, "_end_busy"}, 32'(busy), 0);
        check({name, "_end_I"}, 32'(I_out), 0);
        check({name, "_end_Q"}, 32'(Q_out), 0);
        check({name, "_underrun"}, 32'(underrun), (withhold > 0) ? 1 : 0);
      end else begin
        check({name, "_idle_busy"}, 32'(busy), 0);
        check({name, "_idle_done"}, 32'(done), 0);
      end
      @(posedge clk); #1;
      if (tk) taken++;
      data_valid = (taken < offer);
      data       = pdu[taken & 63];
      start      = (poke != 0) && (k + 1 == poke);
      if (start) begin aa = ~a; pdu_len = 8'd20; end
    end
    start = 1'b0; data_valid = 1'b0;
    check({name, "_bit_errs"}, bit_err, 0);
    check({name, "_strobe_errs"}, stb_err, 0);
    check({name, "_ctrl_errs"}, en_err, 0);
    check({name, "_iq_errs"}, iq_err, 0);
    check({name, "_bytes_taken"}, taken, offer);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; aa = '0; chan_idx = '0; pdu_len = '0; data = '0; data_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tx_en", 32'(tx_en), 0);
    check("rst_ready", 32'(data_ready), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_strobe", 32'(sym_strobe), 0);
    check("rst_tx_bit", 32'(tx_bit), 0);
    check("rst_I", 32'(I_out), 0);
    check("rst_Q", 32'(Q_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    pdu[0] = 8'h00; pdu[1] = 8'h00;
    run_packet("adv_ch37", 32'h8E89BED6, 6'd37, 8'd2, 0, 0, 1'b1);

    pdu[0] = 8'h42; pdu[1] = 8'h04; pdu[2] = 8'hA1; pdu[3] = 8'hB2; pdu[4] = 8'hC3; pdu[5] = 8'hD4;
    run_packet("adv_ch0_poke", 32'h8E89BED6, 6'd0, 8'd6, 0, 200, 1'b0);

    pdu[0] = 8'hAB; pdu[1] = 8'hCD;
    run_packet("clamp_lo_donestart", 32'h12345677, 6'd12, 8'd1, 0, 81 * SPS / 1 - 7, 1'b0);

    for (int i = 0; i < 64; i++) pdu[i] = 8'(i * 37 + 5);
    run_packet("clamp_hi", 32'h50A3C3F1, 6'd39, 8'd45, 0, 0, 1'b0);

    run_packet("underrun", 32'h8E89BED6, 6'd37, 8'd4, 1, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("underrun_sticky", 32'(underrun), 1);

    pdu[0] = 8'h11; pdu[1] = 8'h22; pdu[2] = 8'h33;
    run_packet("after_underrun", 32'hA5A5A5A4, 6'd5, 8'd3, 0, 0, 1'b0);

    @(posedge clk); #1;
    aa = 32'h8E89BED6; chan_idx = 6'd37; pdu_len = 8'd2; data_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("pre_ready", 32'(data_ready), 0);
    repeat (70) @(posedge clk);
    @(negedge clk);
    check("aa_ready", 32'(data_ready), 1);
    check("aa_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_tx_en", 32'(tx_en), 0);
    check("midrst_ready", 32'(data_ready), 0);
    check("midrst_strobe", 32'(sym_strobe), 0);
    check("midrst_I", 32'(I_out), 0);
    check("midrst_Q", 32'(Q_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    pdu[0] = 8'h00; pdu[1] = 8'h00;
    run_packet("restart", 32'h8E89BED6, 6'd37, 8'd2, 0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
